// File: rtl/uart_tx_fast.sv
// UART transmitter at 3 clocks per bit: start, DATA_WIDTH bits LSB-first, optional parity, stop.
// Define UART_TX_FAST_BREAK_EN to add the i_break input and the line-break state.
module uart_tx_fast #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter string       PARITY_CHECK = "NONE",
    parameter int unsigned CLK_FREQ     = 240000000,
    parameter int unsigned BAUD_RATE    = 80000000,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_data,
`ifdef UART_TX_FAST_BREAK_EN
    input  logic                  i_break,
`endif
    output logic                  tx,
    output logic                  busy
);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_err_width
        $error("uart_tx_fast: DATA_WIDTH must be in 2..8");
    end
    if (PARITY_CHECK != "NONE" && PARITY_CHECK != "EVEN" && PARITY_CHECK != "ODD")
    begin : g_err_parity
        $fatal(1, "uart_tx_fast: PARITY_CHECK must be NONE, EVEN or ODD");
    end
    if (CLK_FREQ != 3 * BAUD_RATE) begin : g_err_baud
        $fatal(1, "uart_tx_fast: CLK_FREQ/BAUD_RATE must equal 3");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $fatal(1, "uart_tx_fast: STOP_BITS must be 1 or 2");
    end

    localparam bit         PAR_EN    = (PARITY_CHECK != "NONE");
    localparam bit         PAR_ODD   = (PARITY_CHECK == "ODD");
    localparam logic [2:0] LAST_BIT  = 3'(DATA_WIDTH - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_TX_FAST_BREAK_EN
        ,
        StBreak,
        StBreakMark
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              phase_q, phase_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    rdy_q, rdy_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    bit_end;
    logic                    brk_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= 2'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_end   = (phase_q == 2'd0);
`ifdef UART_TX_FAST_BREAK_EN
        brk_req   = i_break && (state_q == StIdle);
`else
        brk_req   = 1'b0;
`endif
        // rdy_q is only high in IDLE or the final stop-bit cycle
        accept    = i_vld && rdy_q && !brk_req;

        case (state_q)
            StIdle: begin
                if (brk_req) begin
`ifdef UART_TX_FAST_BREAK_EN
                    state_d = StBreak;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    phase_d   = 2'd2;
                    bit_cnt_d = 3'd0;
                end else begin
                    phase_d = phase_q - 2'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    phase_d = 2'd2;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = PAR_EN ? StParity : StStop;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    phase_d = phase_q - 2'd1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d   = StStop;
                    phase_d   = 2'd2;
                    bit_cnt_d = 3'd0;
                end else begin
                    phase_d = phase_q - 2'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = StIdle;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 2'd2;
                    end
                end else begin
                    phase_d = phase_q - 2'd1;
                end
            end
`ifdef UART_TX_FAST_BREAK_EN
            StBreak: begin
                if (!i_break) begin
                    state_d = StBreakMark;
                    phase_d = 2'd2;
                end
            end
            StBreakMark: begin
                if (bit_end) begin
                    state_d = StIdle;
                end else begin
                    phase_d = phase_q - 2'd1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                phase_d = 2'd0;
            end
        endcase

        // An accept overrides the end-of-frame return to IDLE, giving gapless frames
        if (accept) begin
            state_d   = StStart;
            phase_d   = 2'd2;
            bit_cnt_d = 3'd0;
            shift_d   = i_data;
            par_d     = (^i_data) ^ PAR_ODD;
        end
    end

    // Outputs are decoded from next state so they land in registers
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
`ifdef UART_TX_FAST_BREAK_EN
            StBreak:  tx_d = 1'b0;
`endif
            default:  tx_d = 1'b1;
        endcase
        rdy_d  = (state_d == StIdle) ||
                 ((state_d == StStop) && (phase_d == 2'd0) && (bit_cnt_d == LAST_STOP));
        busy_d = (state_d != StIdle);
    end

    assign tx    = tx_q;
    assign o_rdy = rdy_q;
    assign busy  = busy_q;

endmodule
